// File: rtl/pipe_control_unit.sv
// pipe_control_unit
//   Decodes the ID-stage instruction into a control bundle and carries it
//   through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards,
//   applies branch/jump flushes and a global hold, produces EX operand
//   forwarding selects and keeps saturating stall/flush event counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   hold                     freeze every register and counter
//   id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd
//                            ID-stage instruction
//   ex_redirect              branch taken / jump resolved in EX
//   stall, flush, id_illegal combinational hazard / decode status
//   ex_*, mem_*, wb_*        pipeline register contents
//   fwd_a, fwd_b             EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt, flush_cnt     saturating event counters
module pipe_control_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned EN_FWD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush,
    output logic              id_illegal,
    output logic              ex_valid,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic [1:0]        ex_a_sel,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [1:0]        ex_wb_sel,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_reg_write,
    output logic [1:0]        mem_wb_sel,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [1:0]        wb_wb_sel,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic [1:0] a_sel;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_t;

    // funct fields do not affect the control bundle in this core
    logic unused_funct;
    assign unused_funct = ^{id_funct3, id_funct7};

    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_mem_read_q, mem_mem_read_d;
    logic              mem_mem_write_q, mem_mem_write_d;
    logic              mem_reg_write_q, mem_reg_write_d;
    logic [1:0]        mem_wb_sel_q, mem_wb_sel_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [1:0]        wb_wb_sel_q, wb_wb_sel_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    ctrl_t dec;
    logic  known, uses_rs1, uses_rs2, load_use;

    always_comb begin
        dec      = '0;
        known    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011: begin dec = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b0010011: begin dec = '{2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00}; uses_rs1 = 1'b1; end
            7'b0000011: begin dec = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01}; uses_rs1 = 1'b1; end
            7'b0100011: begin dec = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100011: begin dec = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100111: begin dec = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10}; uses_rs1 = 1'b1; end
            7'b1101111: dec = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
            7'b0010111: dec = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
            7'b0110111: dec = '{2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
            default:    known = 1'b0;
        endcase
    end

    assign id_illegal = id_valid & ~known;

    assign load_use = ex_valid_q & ex_ctrl_q.mem_read & (ex_rd_q != '0) & id_valid &
                      ((uses_rs1 & (ex_rd_q == id_rs1)) | (uses_rs2 & (ex_rd_q == id_rs2)));

    // redirect wins: the consumer is squashed anyway, so it must not also stall
    assign flush = ex_redirect;
    assign stall = load_use & ~ex_redirect;

    // EX/MEM forwarding only for ALU results; loads and PC+4 are not ready there
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (mem_valid_q && mem_reg_write_q && (mem_rd_q != '0) && (mem_rd_q == rs) && (mem_wb_sel_q == 2'b00))
            return 2'b10;
        else if (wb_valid_q && wb_reg_write_q && (wb_rd_q != '0) && (wb_rd_q == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = (EN_FWD != 0) ? fwd_sel(ex_rs1_q) : 2'b00;
    assign fwd_b = (EN_FWD != 0) ? fwd_sel(ex_rs2_q) : 2'b00;

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_ctrl_d       = ex_ctrl_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        mem_valid_d     = mem_valid_q;
        mem_mem_read_d  = mem_mem_read_q;
        mem_mem_write_d = mem_mem_write_q;
        mem_reg_write_d = mem_reg_write_q;
        mem_wb_sel_d    = mem_wb_sel_q;
        mem_rd_d        = mem_rd_q;
        wb_valid_d      = wb_valid_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_wb_sel_d     = wb_wb_sel_q;
        wb_rd_d         = wb_rd_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (!hold) begin
            if (flush || stall || !id_valid || !known) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                ex_rs1_d   = '0;
                ex_rs2_d   = '0;
                ex_rd_d    = '0;
            end else begin
                ex_valid_d = 1'b1;
                ex_ctrl_d  = dec;
                ex_rs1_d   = id_rs1;
                ex_rs2_d   = id_rs2;
                ex_rd_d    = id_rd;
            end
            mem_valid_d     = ex_valid_q;
            mem_mem_read_d  = ex_ctrl_q.mem_read;
            mem_mem_write_d = ex_ctrl_q.mem_write;
            mem_reg_write_d = ex_ctrl_q.reg_write;
            mem_wb_sel_d    = ex_ctrl_q.wb_sel;
            mem_rd_d        = ex_rd_q;
            wb_valid_d      = mem_valid_q;
            wb_reg_write_d  = mem_reg_write_q;
            wb_wb_sel_d     = mem_wb_sel_q;
            wb_rd_d         = mem_rd_q;
            if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_ctrl_q       <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            mem_valid_q     <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            mem_mem_write_q <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_wb_sel_q    <= '0;
            mem_rd_q        <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_wb_sel_q     <= '0;
            wb_rd_q         <= '0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_ctrl_q       <= ex_ctrl_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            mem_valid_q     <= mem_valid_d;
            mem_mem_read_q  <= mem_mem_read_d;
            mem_mem_write_q <= mem_mem_write_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_wb_sel_q    <= mem_wb_sel_d;
            mem_rd_q        <= mem_rd_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_wb_sel_q     <= wb_wb_sel_d;
            wb_rd_q         <= wb_rd_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_a_sel      = ex_ctrl_q.a_sel;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_jump       = ex_ctrl_q.jump;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_wb_sel     = ex_ctrl_q.wb_sel;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign mem_valid     = mem_valid_q;
    assign mem_mem_read  = mem_mem_read_q;
    assign mem_mem_write = mem_mem_write_q;
    assign mem_reg_write = mem_reg_write_q;
    assign mem_wb_sel    = mem_wb_sel_q;
    assign mem_rd        = mem_rd_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_wb_sel     = wb_wb_sel_q;
    assign wb_rd         = wb_rd_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit (counters narrowed to 2 bits so that
// saturation is reachable in a few stalls).
module tb_pipe_control_unit;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst, hold, id_valid, ex_redirect;
    logic [6:0]       id_opcode, id_funct7;
    logic [2:0]       id_funct3;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             stall, flush, id_illegal;
    logic             ex_valid, ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [1:0]       ex_alu_op, ex_a_sel, ex_wb_sel;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic             mem_valid, mem_mem_read, mem_mem_write, mem_reg_write;
    logic [1:0]       mem_wb_sel;
    logic [4:0]       mem_rd;
    logic             wb_valid, wb_reg_write;
    logic [1:0]       wb_wb_sel;
    logic [4:0]       wb_rd;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_control_unit #(.REG_AW(5), .CNT_W(CNT_W), .EN_FWD(1)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(stall), .flush(flush), .id_illegal(id_illegal),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_a_sel(ex_a_sel),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wb_sel(wb_wb_sel), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    logic [12:0] ex_ctrl;
    assign ex_ctrl = {ex_alu_op, ex_alu_src, ex_a_sel, ex_branch, ex_jump,
                      ex_mem_read, ex_mem_write, ex_reg_write, ex_wb_sel};

    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011;

    logic [6:0]  ops      [9];
    logic [12:0] exp_ctrl [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid  = v;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        ops      = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                     7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111};
        exp_ctrl = '{13'b10_0_00_0_0_0_0_1_00, 13'b10_1_00_0_0_0_0_1_00,
                     13'b00_1_00_0_0_1_0_1_01, 13'b00_1_00_0_0_0_1_0_00,
                     13'b01_0_00_1_0_0_0_0_00, 13'b00_1_00_0_1_0_0_1_10,
                     13'b00_1_01_0_1_0_0_1_10, 13'b00_1_01_0_0_0_0_1_00,
                     13'b00_1_10_0_0_0_0_1_00};
        id_funct3 = 3'b0; id_funct7 = 7'b0; ex_redirect = 1'b0;

        // reset overrides hold with a valid instruction presented
        rst = 1'b1; hold = 1'b1;
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2);
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        rst = 1'b0; hold = 1'b0;

        // decode sweep
        for (int i = 0; i < 9; i++) begin
            set_id(1'b1, ops[i], 5'(10 + i), 5'd1, 5'd2);
            chk("dec_illegal", id_illegal, 0);
            chk("dec_stall", stall, 0);
            tick();
            chk("dec_ex_valid", ex_valid, 1);
            chk($sformatf("dec_ctrl_%0d", i), ex_ctrl, exp_ctrl[i]);
            chk("dec_ex_rd", ex_rd, 10 + i);
        end
        set_id(1'b1, 7'b1111111, 5'd20, 5'd1, 5'd2);
        chk("illegal_flag", id_illegal, 1);
        tick();
        chk("illegal_bubble_valid", ex_valid, 0);
        chk("illegal_bubble_ctrl", ex_ctrl, 0);
        chk("illegal_bubble_rd", ex_rd, 0);
        chk("latency_mem_rd", mem_rd, 18);
        chk("latency_mem_rw", mem_reg_write, 1);
        chk("latency_wb_rd", wb_rd, 17);
        chk("latency_wb_valid", wb_valid, 1);

        // load-use: lw x5 ; add x6,x5,x7
        drain();
        set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0);
        tick();
        set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd7);
        chk("lu_stall", stall, 1);
        chk("lu_flush", flush, 0);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_mem_load", mem_mem_read, 1);
        chk("lu_stall_once", stall, 0);
        tick();
        chk("lu_ex_rs1", ex_rs1, 5);
        chk("lu_wb_rd", wb_rd, 5);
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);
        chk("lu_stall_cnt", stall_cnt, 1);
        // load to x0 never stalls
        set_id(1'b1, OP_LD, 5'd0, 5'd1, 5'd0);
        tick();
        set_id(1'b1, OP_R, 5'd6, 5'd0, 5'd7);
        chk("lu_x0_stall", stall, 0);
        tick();
        chk("lu_x0_ex_valid", ex_valid, 1);
        chk("lu_x0_stall_cnt", stall_cnt, 1);

        // forwarding from EX/MEM
        drain();
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2); tick();
        set_id(1'b1, OP_R, 5'd4, 5'd3, 5'd3); tick();
        chk("fwd_mem", {fwd_a, fwd_b}, 4'b1010);
        // forwarding from MEM/WB with one independent instruction between
        drain();
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2); tick();
        set_id(1'b1, OP_R, 5'd9, 5'd1, 5'd2); tick();
        set_id(1'b1, OP_R, 5'd4, 5'd3, 5'd3); tick();
        chk("fwd_wb", {fwd_a, fwd_b}, 4'b0101);
        // both stages match: newer EX/MEM result wins
        drain();
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2); tick();
        set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd2); tick();
        set_id(1'b1, OP_R, 5'd4, 5'd3, 5'd8); tick();
        chk("fwd_prio", {fwd_a, fwd_b}, 4'b1000);

        // redirect beats load-use
        drain();
        do_reset();
        set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0); tick();
        set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd7);
        ex_redirect = 1'b1; #1;
        chk("rd_flush", flush, 1);
        chk("rd_stall", stall, 0);
        tick();
        ex_redirect = 1'b0; #1;
        chk("rd_bubble", ex_valid, 0);
        chk("rd_flush_cnt", flush_cnt, 1);
        chk("rd_stall_cnt", stall_cnt, 0);

        // hold during a stall, then counter saturation
        drain();
        do_reset();
        set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0); tick();
        set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd7);  tick();
        set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0); tick();
        set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd7);
        hold = 1'b1; #1;
        chk("hold_stall_comb", stall, 1);
        tick(); tick();
        chk("hold_ex_valid", ex_valid, 1);
        chk("hold_ex_rd", ex_rd, 5);
        chk("hold_ex_mem_read", ex_mem_read, 1);
        chk("hold_mem_valid", mem_valid, 0);
        chk("hold_wb_rd", {wb_valid, wb_rd}, {1'b1, 5'd5});
        chk("hold_stall_cnt", stall_cnt, 1);
        hold = 1'b0;
        tick();
        chk("post_hold_bubble", ex_valid, 0);
        chk("post_hold_cnt", stall_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0); tick();
            set_id(1'b1, OP_R, 5'd6, 5'd5, 5'd7);  tick();
        end
        chk("sat_stall_cnt", stall_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
